serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that sits directly upstream of the 1-bit Fulladder stage.
- Accepts two WIDTH-bit operands plus carry-in and streams them LSB-first into an external Fulladder, one bit per clock.
- Feeds the registered carry back into the adder and shifts the adder's sum bit into a result register.
- Presents the full WIDTH-bit sum and carry-out with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, 4, counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk      input   1       system clock, all state on rising edge
rst_n    input   1       asynchronous active-low reset
start    input   1       request an addition; sampled only in IDLE
a        input   WIDTH   operand A, captured on accepted start
b        input   WIDTH   operand B, captured on accepted start
cin      input   1       initial carry, captured on accepted start
busy     output  1       high while bits are being streamed (SHIFT)
done     output  1       one-cycle pulse: sum/cout valid
sum      output  WIDTH   result, held until next accepted start
cout     output  1       final carry, held until next accepted start
fa_a     output  1       bit to Fulladder A
fa_b     output  1       bit to Fulladder B
fa_cin   output  1       carry to Fulladder Cin
fa_s     input   1       Fulladder S
fa_cout  input   1       Fulladder Cout

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE.
  - Operand shift regs, sum reg, carry reg and bit counter cleared to 0.
  - busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0.
  - Any in-flight addition is discarded, with no done pulse.
- States: IDLE, SHIFT, DONE (2-bit encoding, registered).
- IDLE:
  - On start=1 at an edge, load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, sum_sr<=0, and go to SHIFT.
  - Otherwise hold; sum/cout keep their last values.
- SHIFT:
  - Combinational drive: fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry.
  - Each edge: sum_sr<={fa_s, sum_sr[WIDTH-1:1]}, a_sr>>=1, b_sr>>=1, carry<=fa_cout, cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge (last bit), go to DONE.
  - cout<=fa_cout and sum<={fa_s, sum_sr[WIDTH-1:1]} are updated on that same edge.
- DONE:
  - done=1 for exactly one cycle, then unconditionally return to IDLE.
- Outside SHIFT, fa_a/fa_b/fa_cin are 0.
- busy=1 iff state==SHIFT; done=1 iff state==DONE. Both are decoded from registered state, so they are glitch-free.
- Latency: start accepted at edge 0 gives SHIFT during cycles 1..WIDTH, and done high in the cycle following edge WIDTH. Total is WIDTH+1 cycles from start acceptance to the done pulse.
- Throughput: one addition per WIDTH+2 cycles. A start asserted during SHIFT or DONE is ignored, not queued. A start held high through DONE is accepted at the first IDLE edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2**(WIDTH+1). Overflow is indicated only by cout.
- Operand inputs a/b/cin may change freely after acceptance with no effect on the result.
- The sum/cout registers are only written on the final SHIFT edge, so intermediate bits never appear on sum.

Test Plan:
- Bench setup: Fulladder is instantiated on the fa_* ports; WIDTH=8.
- Basic add: a=8'h5A, b=8'h3C, cin=0, 1-cycle start -> busy high 8 cycles; done pulses 9 cycles after the start edge; sum=8'h96, cout=0.
- Carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start: start a=8'h10/b=8'h20, then pulse start with a=8'h77 on SHIFT cycle 3 and again in the DONE cycle -> single done, sum=8'h30. Next start in IDLE is accepted.
- Reset mid-operation: drop rst_n during SHIFT cycle 4 (asynchronously, between edges) -> busy, sum, cout and fa_* go 0 immediately; no done pulse. After release, a=8'h01+b=8'h01 -> sum=8'h02.
- Exhaustive random: 1000 random a/b/cin with back-to-back starts -> every {cout,sum} matches a+b+cin. Hold values persist until the next start; done is never asserted for more than one cycle.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller for an external 1-bit Fulladder. Operands are
//   captured on an accepted start and streamed LSB-first, one bit per clock.
//   The registered carry is fed back into the adder, and the adder's sum bit
//   is shifted into a result register. When the last bit completes, the full
//   WIDTH-bit sum and carry-out are published and done pulses for one cycle.
//
// Ports
//   clk      in   system clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request an addition, sampled only in IDLE
//   a, b     in   WIDTH-bit operands, captured on accepted start
//   cin      in   initial carry, captured on accepted start
//   busy     out  high while bits are streamed (SHIFT)
//   done     out  one-cycle pulse, sum/cout valid
//   sum      out  WIDTH-bit result, held until the next accepted start
//   cout     out  final carry, held until the next accepted start
//   fa_a     out  operand A bit to the Fulladder
//   fa_b     out  operand B bit to the Fulladder
//   fa_cin   out  carry to the Fulladder
//   fa_s     in   Fulladder sum bit
//   fa_cout  in   Fulladder carry out
//
// States
//   state | meaning
//   IDLE  | waiting for start, result registers hold the last answer
//   SHIFT | one operand bit pair per clock through the Fulladder
//   DONE  | result valid, done pulse, always returns to IDLE

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             load;
  logic             step;
  logic             last_bit;
  logic [WIDTH-1:0] sum_next;

  assign last_bit = (cnt == LAST_CNT);
  // Sum bit from the adder enters at the MSB; after WIDTH steps the first
  // (LSB) result bit has reached bit 0.
  assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_cin  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        step   = 1'b1;
        fa_a   = a_sr[0];
        fa_b   = b_sr[0];
        fa_cin = carry;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_next;
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
    end
  end

  // Published result is written only on the final bit, so partial sums never
  // show on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (step && last_bit) begin
      sum_q  <= sum_next;
      cout_q <= fa_cout;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_s;
  logic       fa_cout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_s   (fa_s),
    .fa_cout(fa_cout)
  );

  // Fulladder stage
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // Issues one addition starting at a negedge and returns at the negedge where
  // done is seen (or after a 20-cycle bound). With from_done, start is raised
  // during the DONE cycle and held into IDLE.
  task automatic do_add(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                        input bit from_done, output int lat, output int busy_n,
                        output bit sum_moved, output logic idle_done, output logic [8:0] idle_res);
    logic [8:0] held;
    a = ia; b = ib; cin = icin; start = 1'b1;
    idle_done = 1'b0;
    idle_res  = {cout, sum};
    if (from_done) begin
      @(posedge clk); @(negedge clk);
      idle_done = done;
      idle_res  = {cout, sum};
    end
    held = {cout, sum};
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 1; busy_n = 0; sum_moved = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if ({cout, sum} !== held) sum_moved = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, sum, cout, fa_a, fa_b, fa_cin} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0", {busy, done, sum, cout, fa_a, fa_b, fa_cin});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle got busy/done=%b want=00", {busy, done});
    end
  endtask

  task automatic test_basic;
    int lat, bn; bit mv; logic id; logic [8:0] ir;
    do_add(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bn, mv, id, ir);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d want=9", lat); end
    n_checks++;
    if (bn !== 8) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d want=8", bn); end
    n_checks++;
    if ({cout, sum} !== 9'h096) begin n_fail++; $display("FAIL basic_sum got=%h want=096", {cout, sum}); end
    n_checks++;
    if (mv !== 1'b0) begin n_fail++; $display("FAIL basic_sum_early got=%b want=0", mv); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_carry;
    int lat, bn; bit mv; logic id; logic [8:0] ir;
    do_add(8'hFF, 8'h01, 1'b0, 1'b0, lat, bn, mv, id, ir);
    n_checks++;
    if ({cout, sum} !== 9'h100) begin n_fail++; $display("FAIL carry_ff_01 got=%h want=100", {cout, sum}); end
    @(negedge clk);
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bn, mv, id, ir);
    n_checks++;
    if ({cout, sum} !== 9'h1FF) begin n_fail++; $display("FAIL carry_ff_ff_1 got=%h want=1ff", {cout, sum}); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int n_done; int lat, bn; bit mv; logic id; logic [8:0] ir;
    n_done = 0;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h77; start = 1'b1;          // SHIFT cycle 3
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12 && !done; i++) @(negedge clk);
    if (done) n_done++;
    a = 8'h77; start = 1'b1;          // DONE cycle
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({cout, sum} !== 9'h030) begin n_fail++; $display("FAIL ignored_sum got=%h want=030", {cout, sum}); end
    for (int i = 0; i < 12; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL ignored_done_count got=%0d want=1", n_done); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_not_requeued got busy=%b want=0", busy); end
    do_add(8'h77, 8'h01, 1'b0, 1'b0, lat, bn, mv, id, ir);
    n_checks++;
    if ({cout, sum} !== 9'h078 || lat !== 9) begin
      n_fail++; $display("FAIL ignored_next_start got=%h lat=%0d want=078 lat=9", {cout, sum}, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n_done; int lat, bn; bit mv; logic id; logic [8:0] ir;
    n_done = 0;
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);        // SHIFT cycle 4
    n_checks++;
    if ({busy, fa_a, fa_b} !== 3'b111) begin n_fail++; $display("FAIL midrst_pre got=%b want=111", {busy, fa_a, fa_b}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, sum, cout, fa_a, fa_b, fa_cin} !== 13'd0) begin
      n_fail++; $display("FAIL midrst_async got=%b want=0", {busy, sum, cout, fa_a, fa_b, fa_cin});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d want=0", n_done); end
    do_add(8'h01, 8'h01, 1'b0, 1'b0, lat, bn, mv, id, ir);
    n_checks++;
    if ({cout, sum} !== 9'h002) begin n_fail++; $display("FAIL midrst_after got=%h want=002", {cout, sum}); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] ra, rb; logic rc; logic [8:0] exp_res, prev;
    int lat, bn; bit mv; logic id; logic [8:0] ir;
    int bad_sum, bad_lat, bad_hold, bad_done;
    bad_sum = 0; bad_lat = 0; bad_hold = 0; bad_done = 0;
    prev = {cout, sum};
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp_res = ref_add(ra, rb, rc);
      do_add(ra, rb, rc, (i != 0), lat, bn, mv, id, ir);
      n_checks++;
      if ({cout, sum} !== exp_res) begin
        n_fail++; bad_sum++;
        if (bad_sum < 5) $display("FAIL rand_sum a=%h b=%h c=%b got=%h want=%h", ra, rb, rc, {cout, sum}, exp_res);
      end
      n_checks++;
      if (lat !== 9 || bn !== 8) begin
        n_fail++; bad_lat++;
        if (bad_lat < 5) $display("FAIL rand_timing got lat=%0d busy=%0d want lat=9 busy=8", lat, bn);
      end
      n_checks++;
      if (mv || ir !== prev) begin
        n_fail++; bad_hold++;
        if (bad_hold < 5) $display("FAIL rand_hold got=%h moved=%b want=%h", ir, mv, prev);
      end
      if (i != 0) begin
        n_checks++;
        if (id !== 1'b0) begin
          n_fail++; bad_done++;
          if (bad_done < 5) $display("FAIL rand_done_width got=%b want=0", id);
        end
      end
      prev = exp_res;
    end
    @(negedge clk);
    n_checks++;
    if ({cout, sum} !== prev || done !== 1'b0) begin
      n_fail++; $display("FAIL rand_final_hold got=%h done=%b want=%h done=0", {cout, sum}, done, prev);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule
